// File: rtl/dinorun_pkg.sv
// dinorun_pkg: shared screen geometry and VGA 640x480 @ 60 Hz timing constants.
// All raster region bounds are derived here from the porch/sync widths so that
// the timing generator never carries bare literals.
package dinorun_pkg;

    localparam int ScreenWidth  = 640;
    localparam int ScreenHeight = 480;

    // Horizontal timing, in pixel clocks.
    localparam int HFrontPorch = 16;
    localparam int HSyncWidth  = 96;
    localparam int HBackPorch  = 48;
    localparam int HTotal      = ScreenWidth + HFrontPorch + HSyncWidth + HBackPorch; // 800

    // Vertical timing, in lines.
    localparam int VFrontPorch = 10;
    localparam int VSyncWidth  = 2;
    localparam int VBackPorch  = 33;
    localparam int VTotal      = ScreenHeight + VFrontPorch + VSyncWidth + VBackPorch; // 525

    typedef logic [9:0] coord_t;

    // Region bounds as coordinates (half-open: start <= c < end).
    localparam coord_t HVisEnd    = coord_t'(ScreenWidth);
    localparam coord_t HSyncStart = coord_t'(ScreenWidth + HFrontPorch);
    localparam coord_t HSyncEnd   = coord_t'(ScreenWidth + HFrontPorch + HSyncWidth);
    localparam coord_t VVisEnd    = coord_t'(ScreenHeight);
    localparam coord_t VSyncStart = coord_t'(ScreenHeight + VFrontPorch);
    localparam coord_t VSyncEnd   = coord_t'(ScreenHeight + VFrontPorch + VSyncWidth);

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-(Max+1) up-counter with synchronous active-high reset.
//   clk_i   - clock
//   rst_i   - synchronous reset, active high, clears the count
//   inc_i   - advance by one on this edge
//   count_o - current count, 0..Max
//   wrap_o  - high while count_o == Max (the next increment wraps to 0)
module wrap_counter #(
    parameter int Max   = 1,
    parameter int Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o,
    output logic             wrap_o
);

    localparam logic [Width-1:0] MaxVal = Width'(Max);

    // Exact compare against Max: the count never reaches Max+1.
    assign wrap_o = (count_o == MaxVal);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (inc_i) begin
            count_o <= wrap_o ? '0 : count_o + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: 640x480 @ 60 Hz raster timing from the 25.175 MHz pixel clock.
//   clk_i         - pixel clock
//   rst_i         - synchronous reset, active high (overrides en_i)
//   en_i          - pixel-advance enable; gates every state update
//   hsync_o       - horizontal sync, active low
//   vsync_o       - vertical sync, active low
//   visible_o     - high inside the 640x480 visible area
//   pixel_x_o     - horizontal position 0..799
//   pixel_y_o     - vertical position 0..524
//   line_start_o  - high for the pixel with x == 0
//   frame_start_o - high for the pixel with x == 0 and y == 0
//   frame_count_o - completed frames, wraps modulo 2^FrameCountWidth
// Every output is a registered decode of the same (h, v) counter pair, so all
// outputs describe one pixel in one cycle. Strobes hold while en_i is low.
module vga_timing
    import dinorun_pkg::*;
#(
    parameter int FrameCountWidth = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    output logic                       hsync_o,
    output logic                       vsync_o,
    output logic                       visible_o,
    output logic [9:0]                 pixel_x_o,
    output logic [9:0]                 pixel_y_o,
    output logic                       line_start_o,
    output logic                       frame_start_o,
    output logic [FrameCountWidth-1:0] frame_count_o
);

    coord_t                     h_cnt;
    coord_t                     v_cnt;
    logic                       h_wrap;
    logic                       v_wrap;
    logic [FrameCountWidth-1:0] frame_cnt;

    wrap_counter #(.Max(HTotal - 1), .Width($bits(coord_t))) u_h_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (en_i),
        .count_o (h_cnt),
        .wrap_o  (h_wrap)
    );

    wrap_counter #(.Max(VTotal - 1), .Width($bits(coord_t))) u_v_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (h_wrap & en_i),
        .count_o (v_cnt),
        .wrap_o  (v_wrap)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hsync_o       <= 1'b1;
            vsync_o       <= 1'b1;
            visible_o     <= 1'b0;
            pixel_x_o     <= '0;
            pixel_y_o     <= '0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
            frame_count_o <= '0;
            frame_cnt     <= '0;
        end else if (en_i) begin
            hsync_o       <= !((h_cnt >= HSyncStart) && (h_cnt < HSyncEnd));
            vsync_o       <= !((v_cnt >= VSyncStart) && (v_cnt < VSyncEnd));
            visible_o     <= (h_cnt < HVisEnd) && (v_cnt < VVisEnd);
            pixel_x_o     <= h_cnt;
            pixel_y_o     <= v_cnt;
            line_start_o  <= (h_cnt == '0);
            frame_start_o <= (h_cnt == '0) && (v_cnt == '0);
            // frame_cnt bumps on the (799,524)->(0,0) edge; the output copy
            // lags one enabled edge so the new value lands with frame_start_o.
            frame_count_o <= frame_cnt;
            if (h_wrap && v_wrap) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed self-checking bench for vga_timing.
// Long stretches of the raster are skipped by forcing the two counters to a
// chosen position just before a clock edge; everything else runs naturally.
module tb_vga_timing;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       hsync, vsync, visible, line_start, frame_start;
    logic [9:0] pixel_x, pixel_y;
    logic [1:0] frame_count;

    int checks   = 0;
    int failures = 0;

    logic [9:0] jump_x, jump_y;

    always #5 clk = ~clk;

    vga_timing #(.FrameCountWidth(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .hsync_o       (hsync),
        .vsync_o       (vsync),
        .visible_o     (visible),
        .pixel_x_o     (pixel_x),
        .pixel_y_o     (pixel_y),
        .line_start_o  (line_start),
        .frame_start_o (frame_start),
        .frame_count_o (frame_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock: outputs are sampled on the falling edge, inputs change there.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Place the counters at (x, y); after the following edge the outputs show it.
    task jump(input logic [9:0] x, input logic [9:0] y);
        jump_x = x;
        jump_y = y;
        force dut.u_h_cnt.count_o = jump_x;
        force dut.u_v_cnt.count_o = jump_y;
        #1;
        release dut.u_h_cnt.count_o;
        release dut.u_v_cnt.count_o;
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_flags"}, {hsync, vsync, visible, line_start, frame_start}, 5'b11000);
        check({tag, "_x"}, pixel_x, 0);
        check({tag, "_y"}, pixel_y, 0);
        check({tag, "_fc"}, frame_count, 0);
    endtask

    initial begin
        int n, low_cnt, en_ticks, frz_err, prev_fc;
        int vis_cnt, vis_end, hs_low, hs_first, ls_cnt, seq_err;
        int exp_fc [5] = '{1, 2, 3, 0, 1};

        // Reset held 3 clocks with en high: reset wins.
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset_values("reset");
        end
        rst = 1'b0;
        tick();
        check("first_pix_flags", {visible, line_start, frame_start}, 3'b111);
        check("first_pix_xy", {pixel_x, pixel_y}, 0);
        check("first_pix_fc", frame_count, 0);

        // Horizontal timing across two lines.
        for (int l = 0; l < 2; l++) begin
            vis_cnt = 0; vis_end = -1; hs_low = 0; hs_first = -1; ls_cnt = 0; seq_err = 0;
            for (int i = 0; i < 800; i++) begin
                if (pixel_x != i[9:0] || pixel_y != l[9:0]) seq_err++;
                if (visible) vis_cnt++;
                else if (vis_end < 0) vis_end = i;
                if (!hsync) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = i;
                end
                if (line_start) begin
                    ls_cnt++;
                    if (i != 0) seq_err++;
                end
                tick();
            end
            check("h_vis_cnt", vis_cnt, 640);
            check("h_vis_end", vis_end, 640);
            check("h_sync_len", hs_low, 96);
            check("h_sync_start", hs_first, 656);
            check("h_line_start_cnt", ls_cnt, 1);
            check("h_seq_err", seq_err, 0);
        end
        check("h_after_2_lines", {pixel_x, pixel_y}, {10'd0, 10'd2});

        // Vertical timing: vsync window and sync-to-first-pixel distance.
        jump(10'd790, 10'd489);
        n = 0;
        while (vsync && n < 100) begin tick(); n++; end
        check("v_fall_wait", n, 10);
        check("v_fall_pos", {pixel_x, pixel_y}, {10'd0, 10'd490});
        low_cnt = 0;
        while (!vsync && low_cnt < 2000) begin tick(); low_cnt++; end
        check("v_sync_len", low_cnt, 1600);
        check("v_rise_pos", {pixel_x, pixel_y}, {10'd0, 10'd492});
        n = 0;
        while (!frame_start && n < 30000) begin tick(); n++; end
        check("v_rise_to_frame", n, 26400);
        check("v_frame_pix", {visible, line_start, pixel_x, pixel_y}, {2'b11, 20'd0});
        check("v_frame_fc", frame_count, 1);

        // Enable gating: freeze at x = 655, hsync falls on first enabled edge.
        en_ticks = 0;
        n = 0;
        while (pixel_x != 10'd655 && n < 800) begin tick(); en_ticks++; n++; end
        check("en_reach_655", pixel_x, 655);
        en = 1'b0;
        frz_err = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (pixel_x != 10'd655 || pixel_y != 10'd0 || !hsync || visible || line_start) frz_err++;
        end
        check("en_freeze_err", frz_err, 0);
        en = 1'b1;
        tick();
        en_ticks++;
        check("en_hsync_fall", {hsync, pixel_x}, {1'b0, 10'd656});
        n = 0;
        while (!line_start && n < 1000) begin tick(); en_ticks++; n++; end
        check("en_line_len", en_ticks, 800);
        // A strobe stretches across disabled cycles.
        en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("en_strobe_hold", {line_start, pixel_x, pixel_y}, {1'b1, 10'd0, 10'd1});
        en = 1'b1;
        tick();
        check("en_strobe_drop", {line_start, pixel_x}, {1'b0, 10'd1});

        // Reset mid-frame at (300, 200).
        jump(10'd300, 10'd200);
        check("mid_pos", {pixel_x, pixel_y}, {10'd300, 10'd200});
        rst = 1'b1;
        tick();
        check_reset_values("mid_reset");
        rst = 1'b0;
        tick();
        check("mid_restart", {frame_start, pixel_x, pixel_y, 2'(frame_count)}, {1'b1, 22'd0});
        jump(10'd795, 10'd524);
        for (int i = 0; i < 4; i++) tick();
        check("mid_last_pix", {frame_start, pixel_x, pixel_y, 2'(frame_count)},
              {1'b0, 10'd799, 10'd524, 2'd0});
        tick();
        check("mid_next_frame", {frame_start, pixel_x, pixel_y, 2'(frame_count)},
              {1'b1, 20'd0, 2'd1});

        // Frame counter wrap with a 2-bit counter: 0, 1, 2, 3, 0, 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("wrap_start", {frame_start, 2'(frame_count)}, {1'b1, 2'd0});
        prev_fc = 0;
        for (int k = 0; k < 5; k++) begin
            jump(10'd797, 10'd524);
            tick();
            tick();
            check("wrap_before", {frame_start, 2'(frame_count)}, {1'b0, prev_fc[1:0]});
            tick();
            check("wrap_after", {frame_start, 2'(frame_count)}, {1'b1, exp_fc[k][1:0]});
            prev_fc = exp_fc[k];
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
